// File: rtl/otbn_loop_nest_ctrl.sv
// Hardware-loop stack controller for the OTBN execute stage.
// Tracks nested loops, requests jumps to loop start, supports break and skip.
module otbn_loop_nest_ctrl #(
    parameter int ImemAddrWidth  = 12,
    parameter int LoopStackDepth = 8,
    parameter int IterWidth      = 32,
    parameter int BodySizeWidth  = 12,
    parameter bit ZeroIterSkip   = 1'b0,
    localparam int DepthWidth    = $clog2(LoopStackDepth + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     state_reset_i,
    input  logic                     insn_valid_i,
    input  logic [ImemAddrWidth-1:0] insn_addr_i,
    input  logic                     stall_i,
    input  logic                     jump_or_branch_i,
    input  logic                     loop_start_req_i,
    input  logic                     loop_start_commit_i,
    input  logic [BodySizeWidth-1:0] loop_bodysize_i,
    input  logic [IterWidth-1:0]     loop_iterations_i,
    input  logic                     loop_break_i,
    output logic                     loop_jump_o,
    output logic [ImemAddrWidth-1:0] loop_jump_addr_o,
    output logic                     loop_skip_o,
    output logic [ImemAddrWidth-1:0] loop_skip_addr_o,
    output logic                     loop_active_o,
    output logic [DepthWidth-1:0]    loop_depth_o,
    output logic [IterWidth-1:0]     cur_iterations_o,
    output logic                     sw_err_o,
    output logic                     hw_err_o
);

    localparam int IdxWidth = $clog2(LoopStackDepth);
    localparam int SumWidth = ImemAddrWidth + BodySizeWidth + 3;

    logic [ImemAddrWidth-1:0] start_q [LoopStackDepth];
    logic [ImemAddrWidth:0]   end_q   [LoopStackDepth];
    logic [IterWidth-1:0]     iters_q [LoopStackDepth];

    logic [DepthWidth-1:0] depth;
    logic [DepthWidth-1:0] depth_inv;
    logic [DepthWidth-1:0] depth_d;
    logic [DepthWidth-1:0] depth_m1;
    logic [IdxWidth-1:0]   top_idx;
    logic [IdxWidth-1:0]   push_idx;
    logic                  hw_err_q;

    logic [SumWidth-1:0]      end_sum;
    logic [ImemAddrWidth:0]   end_new;
    logic [ImemAddrWidth-1:0] start_new;

    logic active, full, at_end, finish, zero_iter, skip_req, skip;
    logic upd, push, pop, dec, mismatch;

    // Any carry out of the address width marks the end as unreachable
    assign end_sum   = SumWidth'(insn_addr_i)
                     + (SumWidth'(loop_bodysize_i) << 2)
                     + SumWidth'(4);
    assign end_new   = {|end_sum[SumWidth-1:ImemAddrWidth],
                        end_sum[ImemAddrWidth-1:0]};
    assign start_new = insn_addr_i + ImemAddrWidth'(4);

    assign depth_m1 = depth - 1'b1;
    assign top_idx  = depth_m1[IdxWidth-1:0];
    assign push_idx = depth[IdxWidth-1:0];
    assign active   = depth != '0;
    assign full     = depth == DepthWidth'(LoopStackDepth);

    assign at_end = active & insn_valid_i
                  & (end_q[top_idx] == {1'b0, insn_addr_i});
    assign finish = at_end & (iters_q[top_idx] == IterWidth'(1));

    assign zero_iter = loop_start_req_i & (loop_iterations_i == '0);
    assign skip_req  = ZeroIterSkip & zero_iter;
    assign skip      = skip_req & ~end_new[ImemAddrWidth];

    assign sw_err_o = (zero_iter & ~ZeroIterSkip)
                    | (skip_req & end_new[ImemAddrWidth])
                    | (loop_start_req_i & full)
                    | (at_end & jump_or_branch_i)
                    | (at_end & loop_start_req_i)
                    | (loop_break_i & ~active);

    assign upd  = ~stall_i & ~state_reset_i;
    assign push = upd & loop_start_req_i & loop_start_commit_i
                & ~sw_err_o & ~skip_req;
    assign pop  = upd & (finish | loop_break_i) & ~sw_err_o;
    assign dec  = upd & at_end & ~finish & ~loop_break_i & ~sw_err_o;

    always_comb begin
        depth_d = depth;
        if (push) depth_d = depth + 1'b1;
        if (pop)  depth_d = depth - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || state_reset_i) begin
            depth     <= '0;
            depth_inv <= '1;
            for (int i = 0; i < LoopStackDepth; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                iters_q[i] <= '0;
            end
        end else begin
            depth     <= depth_d;
            depth_inv <= ~depth_d;
            if (push) begin
                start_q[push_idx] <= start_new;
                end_q[push_idx]   <= end_new;
                iters_q[push_idx] <= loop_iterations_i;
            end
            if (dec) iters_q[top_idx] <= iters_q[top_idx] - 1'b1;
        end
    end

    assign mismatch = depth != ~depth_inv;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hw_err_q <= 1'b0;
        end else if (mismatch || (dec && iters_q[top_idx] == '0)) begin
            hw_err_q <= 1'b1;
        end
    end

    assign loop_jump_o      = at_end & (iters_q[top_idx] != IterWidth'(1))
                            & ~loop_break_i;
    assign loop_jump_addr_o = active ? start_q[top_idx] : '0;
    assign loop_skip_o      = skip;
    assign loop_skip_addr_o = skip ? end_new[ImemAddrWidth-1:0] : '0;
    assign loop_active_o    = active;
    assign loop_depth_o     = depth;
    assign cur_iterations_o = active ? iters_q[top_idx] : '0;
    assign hw_err_o         = hw_err_q;

endmodule

// File: tb/tb_otbn_loop_nest_ctrl.sv
// Directed bench for otbn_loop_nest_ctrl: one instance without and one
// with zero-iteration skip, driven by the same stimulus.
module tb_otbn_loop_nest_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        state_reset = 1'b0;
    logic        insn_valid = 1'b0;
    logic [11:0] insn_addr = '0;
    logic        stall = 1'b0;
    logic        jb = 1'b0;
    logic        lsr = 1'b0;
    logic        commit = 1'b0;
    logic [11:0] bodysize = '0;
    logic [31:0] iterations = '0;
    logic        brk = 1'b0;

    logic        jump_a, skip_a, active_a, sw_err_a, hw_err_a;
    logic [11:0] jump_addr_a, skip_addr_a;
    logic [3:0]  depth_a;
    logic [31:0] cur_a;

    logic        jump_b, skip_b, active_b, sw_err_b, hw_err_b;
    logic [11:0] jump_addr_b, skip_addr_b;
    logic [3:0]  depth_b;
    logic [31:0] cur_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    otbn_loop_nest_ctrl #(.ZeroIterSkip(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .state_reset_i(state_reset),
        .insn_valid_i(insn_valid), .insn_addr_i(insn_addr),
        .stall_i(stall), .jump_or_branch_i(jb),
        .loop_start_req_i(lsr), .loop_start_commit_i(commit),
        .loop_bodysize_i(bodysize), .loop_iterations_i(iterations),
        .loop_break_i(brk),
        .loop_jump_o(jump_a), .loop_jump_addr_o(jump_addr_a),
        .loop_skip_o(skip_a), .loop_skip_addr_o(skip_addr_a),
        .loop_active_o(active_a), .loop_depth_o(depth_a),
        .cur_iterations_o(cur_a), .sw_err_o(sw_err_a),
        .hw_err_o(hw_err_a)
    );

    otbn_loop_nest_ctrl #(.ZeroIterSkip(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .state_reset_i(state_reset),
        .insn_valid_i(insn_valid), .insn_addr_i(insn_addr),
        .stall_i(stall), .jump_or_branch_i(jb),
        .loop_start_req_i(lsr), .loop_start_commit_i(commit),
        .loop_bodysize_i(bodysize), .loop_iterations_i(iterations),
        .loop_break_i(brk),
        .loop_jump_o(jump_b), .loop_jump_addr_o(jump_addr_b),
        .loop_skip_o(skip_b), .loop_skip_addr_o(skip_addr_b),
        .loop_active_o(active_b), .loop_depth_o(depth_b),
        .cur_iterations_o(cur_b), .sw_err_o(sw_err_b),
        .hw_err_o(hw_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        insn_valid = 1'b0; insn_addr = '0; stall = 1'b0; jb = 1'b0;
        lsr = 1'b0; commit = 1'b0; bodysize = '0; iterations = '0;
        brk = 1'b0; state_reset = 1'b0;
    endtask

    // Present inputs, let combinational outputs settle before the edge
    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] a, input logic [11:0] bs,
                        input logic [31:0] it);
        idle();
        insn_valid = 1'b1; insn_addr = a; lsr = 1'b1; commit = 1'b1;
        bodysize = bs; iterations = it;
        settle();
        chk("push_sw_err", 32'(sw_err_a), 32'd0);
        tick();
        idle();
    endtask

    task automatic at_insn(input logic [11:0] a);
        idle();
        insn_valid = 1'b1; insn_addr = a;
        settle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        settle();
        chk("rst_depth", 32'(depth_a), 32'd0);
        chk("rst_active", 32'(active_a), 32'd0);
        chk("rst_cur", cur_a, 32'd0);
        chk("rst_jump", 32'(jump_a), 32'd0);
        chk("rst_jaddr", 32'(jump_addr_a), 32'd0);
        chk("rst_skip", 32'(skip_b), 32'd0);
        chk("rst_saddr", 32'(skip_addr_b), 32'd0);
        chk("rst_sw_err", 32'(sw_err_a), 32'd0);
        chk("rst_hw_err", 32'(hw_err_a), 32'd0);

        // Single loop: 0x100, body 2 insns, 3 iterations, end 0x108
        push(12'h100, 12'd1, 32'd3);
        chk("l1_depth", 32'(depth_a), 32'd1);
        chk("l1_active", 32'(active_a), 32'd1);
        chk("l1_cur", cur_a, 32'd3);
        chk("l1_jaddr", 32'(jump_addr_a), 32'h104);
        at_insn(12'h104);
        chk("l1_nojump_body", 32'(jump_a), 32'd0);
        at_insn(12'h108);
        chk("l1_jump1", 32'(jump_a), 32'd1);
        tick();
        chk("l1_cur2", cur_a, 32'd2);
        at_insn(12'h108);
        chk("l1_jump2", 32'(jump_a), 32'd1);
        chk("l1_jaddr2", 32'(jump_addr_a), 32'h104);
        tick();
        chk("l1_cur1", cur_a, 32'd1);
        at_insn(12'h108);
        chk("l1_nojump3", 32'(jump_a), 32'd0);
        tick();
        chk("l1_depth0", 32'(depth_a), 32'd0);
        chk("l1_cur0", cur_a, 32'd0);
        at_insn(12'h108);
        chk("l1_gone", 32'(jump_a), 32'd0);

        // Nest 8 deep: level i at 0x400+4i, end 0x500-4i, iters i+2
        for (int i = 0; i < 8; i++) begin
            push(12'(12'h400 + 4 * i), 12'(12'h3f - 2 * i), 32'(i + 2));
            chk("nest_depth", 32'(depth_a), 32'(i + 1));
            chk("nest_cur", cur_a, 32'(i + 2));
        end
        chk("nest_jaddr", 32'(jump_addr_a), 32'h420);
        idle();
        insn_valid = 1'b1; insn_addr = 12'h420; lsr = 1'b1;
        bodysize = 12'd0; iterations = 32'd1;
        settle();
        chk("ovf_sw_err", 32'(sw_err_a), 32'd1);
        tick();
        chk("ovf_depth", 32'(depth_a), 32'd8);
        for (int k = 7; k >= 0; k--) begin
            idle();
            insn_valid = 1'b1; insn_addr = 12'(12'h500 - 4 * k);
            brk = 1'b1;
            settle();
            chk("unw_nojump", 32'(jump_a), 32'd0);
            chk("unw_sw_err", 32'(sw_err_a), 32'd0);
            tick();
            chk("unw_depth", 32'(depth_a), 32'(k));
            chk("unw_cur", cur_a, (k > 0) ? 32'(k + 1) : 32'd0);
        end

        // Zero-iteration LOOPI at 0x200, body 4 insns
        idle();
        insn_valid = 1'b1; insn_addr = 12'h200; lsr = 1'b1;
        bodysize = 12'd3; iterations = 32'd0;
        settle();
        chk("zi_a_sw_err", 32'(sw_err_a), 32'd1);
        chk("zi_a_skip", 32'(skip_a), 32'd0);
        chk("zi_b_skip", 32'(skip_b), 32'd1);
        chk("zi_b_saddr", 32'(skip_addr_b), 32'h210);
        chk("zi_b_sw_err", 32'(sw_err_b), 32'd0);
        tick();
        chk("zi_a_depth", 32'(depth_a), 32'd0);
        chk("zi_b_depth", 32'(depth_b), 32'd0);
        // Skip target beyond Imem is an error, not a skip
        insn_addr = 12'hffc;
        settle();
        chk("zi_ovf_skip", 32'(skip_b), 32'd0);
        chk("zi_ovf_sw_err", 32'(sw_err_b), 32'd1);
        tick();
        chk("zi_ovf_depth", 32'(depth_b), 32'd0);

        // Break at end of 5-iteration loop at 0x300, end 0x304
        push(12'h300, 12'd0, 32'd5);
        idle();
        insn_valid = 1'b1; insn_addr = 12'h304; brk = 1'b1;
        settle();
        chk("brk_nojump", 32'(jump_a), 32'd0);
        chk("brk_sw_err", 32'(sw_err_a), 32'd0);
        tick();
        chk("brk_depth", 32'(depth_a), 32'd0);
        idle();
        brk = 1'b1;
        settle();
        chk("brk_empty_err", 32'(sw_err_a), 32'd1);
        tick();
        chk("brk_empty_depth", 32'(depth_a), 32'd0);

        // Stall at the end instruction holds state, keeps jump visible
        push(12'h300, 12'd0, 32'd4);
        for (int s = 0; s < 3; s++) begin
            idle();
            insn_valid = 1'b1; insn_addr = 12'h304; stall = 1'b1;
            settle();
            chk("stall_jump", 32'(jump_a), 32'd1);
            tick();
            chk("stall_cur", cur_a, 32'd4);
        end
        at_insn(12'h304);
        chk("rel_jump", 32'(jump_a), 32'd1);
        tick();
        chk("rel_cur", cur_a, 32'd3);

        // Branch on the last body instruction is an error; no decrement
        idle();
        insn_valid = 1'b1; insn_addr = 12'h304; jb = 1'b1;
        settle();
        chk("jb_sw_err", 32'(sw_err_a), 32'd1);
        tick();
        chk("jb_cur", cur_a, 32'd3);
        chk("jb_depth", 32'(depth_a), 32'd1);
        idle();
        brk = 1'b1;
        tick();
        chk("jb_pop", 32'(depth_a), 32'd0);

        // state_reset mid-loop at depth 3
        push(12'h600, 12'd9, 32'd2);
        push(12'h604, 12'd6, 32'd2);
        push(12'h608, 12'd3, 32'd2);
        chk("sr_depth3", 32'(depth_a), 32'd3);
        at_insn(12'h618);
        chk("sr_jump_pre", 32'(jump_a), 32'd1);
        state_reset = 1'b1;
        tick();
        state_reset = 1'b0;
        settle();
        chk("sr_depth0", 32'(depth_a), 32'd0);
        chk("sr_active", 32'(active_a), 32'd0);
        chk("sr_nojump", 32'(jump_a), 32'd0);
        chk("sr_hw_err", 32'(hw_err_a), 32'd0);

        // Corrupt the redundant depth copy in one instance only
        idle();
        force dut_a.depth_inv = 4'h0;
        tick();
        release dut_a.depth_inv;
        tick();
        chk("hw_set", 32'(hw_err_a), 32'd1);
        chk("hw_other", 32'(hw_err_b), 32'd0);
        tick();
        chk("hw_sticky", 32'(hw_err_a), 32'd1);
        state_reset = 1'b1;
        tick();
        state_reset = 1'b0;
        tick();
        chk("hw_sr_keep", 32'(hw_err_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("hw_rst_clr", 32'(hw_err_a), 32'd0);
        chk("hw_rst_depth", 32'(depth_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/otbn_loop_nest_ctrl.md
Name: otbn_loop_nest_ctrl

Overview:
Parametrised hardware-loop controller for the OTBN execute stage. It supports a configurable loop-stack depth, iteration counter width and body-size width. It adds three behaviours the previous generation lacks: early loop break, optional zero-iteration skip, and a stack-depth readout. It sits beside the instruction-fetch/execute boundary, tracks the innermost loop, and requests jumps back to the loop start.

Parameters:
ImemAddrWidth, 12, byte address width of Imem
LoopStackDepth, 8, number of nested loops held (>=2)
IterWidth, 32, loop iteration counter width
BodySizeWidth, 12, width of the loop body-size field (instructions minus 1)
ZeroIterSkip, 0, 1: zero-iteration loop skips its body; 0: zero iterations is a software error

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
state_reset_i  in  1  synchronous clear of all loop state (same effect as rst_i except hw_err_o)
insn_valid_i  in  1  insn_addr_i holds a valid executing instruction
insn_addr_i  in  ImemAddrWidth  address of executing instruction
stall_i  in  1  execute stage stalled; no state update this cycle
jump_or_branch_i  in  1  current instruction is a jump/branch
loop_start_req_i  in  1  current instruction is LOOP/LOOPI
loop_start_commit_i  in  1  controller commits the loop start
loop_bodysize_i  in  BodySizeWidth  body size in instructions minus 1
loop_iterations_i  in  IterWidth  requested iterations
loop_break_i  in  1  committed LOOPBRK: abandon innermost loop
loop_jump_o  out  1  jump to loop_jump_addr_o this cycle
loop_jump_addr_o  out  ImemAddrWidth  start address of innermost loop
loop_skip_o  out  1  zero-iteration skip: jump to loop_skip_addr_o
loop_skip_addr_o  out  ImemAddrWidth  first instruction after skipped body
loop_active_o  out  1  stack non-empty
loop_depth_o  out  $clog2(LoopStackDepth+1)  current stack occupancy
cur_iterations_o  out  IterWidth  remaining iterations of innermost loop (0 when empty)
sw_err_o  out  1  software error this cycle (combinational)
hw_err_o  out  1  sticky fault

Behaviour:
- Reset (rst_i): depth=0, all entries zeroed, hw_err sticky=0. All outputs are 0 after reset.
- state_reset_i: depth=0, entries zeroed; hw_err sticky is retained.
- Stack entry fields:
  - start = insn_addr_i+4, truncated to ImemAddrWidth.
  - end = insn_addr_i + 4*(bodysize+1), ImemAddrWidth+1 bits. Bit [ImemAddrWidth] is the OR of all overflow bits of the full-width sum. An entry with this bit set never matches an instruction address.
  - iters = loop_iterations_i.
- at_end = active & insn_valid_i & (top.end == {0,insn_addr_i}).
- Jump and finish (both combinational):
  - loop_jump_o = at_end & top.iters != 1 & ~loop_break_i.
  - finish = at_end & top.iters == 1.
- Update, gated by ~stall_i & ~state_reset_i, taking effect next edge:
  - at_end & ~finish & ~loop_break_i: top.iters -= 1.
  - finish or loop_break_i: pop (depth-1).
  - Push when loop_start_req_i & loop_start_commit_i & ~sw_err_o & ~skip: entry written at index depth, depth+1.
- Skip (ZeroIterSkip=1, loop_start_req_i, iterations==0):
  - loop_skip_o=1, loop_skip_addr_o = end[ImemAddrWidth-1:0].
  - No push.
  - If end overflow bit is set: sw_err_o instead, and loop_skip_o=0.
- sw_err_o is the OR of:
  - zero iterations with ZeroIterSkip=0 and loop_start_req_i;
  - push requested while depth==LoopStackDepth;
  - at_end & jump_or_branch_i;
  - at_end & loop_start_req_i;
  - loop_break_i while depth==0.
- On any sw error, the erroring push/pop does not happen. The commit input must be low when sw_err_o is high.
- Simultaneous events:
  - push+pop cannot co-occur: at_end with loop_start_req_i is already an error.
  - loop_break_i at a loop end pops and suppresses the jump.
  - stall_i blocks pop, push and decrement, but jump/skip/sw_err stay combinationally visible.
- Pop at depth 1 makes the stack empty. cur_iterations_o then reads 0, and the next insn sees no loop.
- hw_err:
  - The depth counter is held with a redundant inverted copy; any mismatch sets the sticky bit.
  - Decrementing iters from 0 also sets it.
  - Cleared only by rst_i.
- loop_depth_o and loop_active_o are registered state, with no combinational path from inputs.

Test Plan:
- Single loop, insn_addr 0x100, bodysize 1, iterations 3 → end 0x108. At the insn at 0x108 loop_jump_o=1 to 0x104 twice. On the third pass there is no jump and depth goes 1→0.
- Nest to LoopStackDepth=8, then a ninth LOOP request → sw_err_o=1, depth stays 8. Unwinding pops each level in order, and cur_iterations_o shows each outer count.
- ZeroIterSkip=1, LOOPI at 0x200, bodysize 3, iterations 0 → loop_skip_o=1 with addr 0x210 and no push. With ZeroIterSkip=0 the same stimulus → sw_err_o=1.
- loop_break_i at the end insn of a loop with iterations 5 → no jump, depth-1. loop_break_i with depth 0 → sw_err_o.
- Hold stall_i for 3 cycles at the end insn → iters unchanged, loop_jump_o held high. Release → a single decrement.
- state_reset_i mid-loop at depth 3 → depth 0 next cycle, no jump, hw_err_o unchanged. Force a depth-copy mismatch → hw_err_o=1, stays set until rst_i.
